eth_vlg_mac_tx: RTL and testbench

ETH_VLG_MAC_TX -- requirements
Module: eth_vlg_mac_tx

---
 rtl/eth_vlg_mac_tx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_eth_vlg_mac_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_vlg_mac_tx.sv
//------------------------------------------------------------------------------
// Module      : eth_vlg_mac_tx
// Description : Byte-wide Ethernet MAC transmitter (preamble, header, padding,
//               CRC-32 FCS, inter-frame gap) with a GMII-style PHY output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package eth_vlg_pkg;
  typedef logic [5:0][7:0] mac_addr_t;
  typedef logic [1:0][7:0] ethertype_t;
  typedef logic [3:0][7:0] ipv4_t;
  typedef struct packed {
    mac_addr_t mac_addr;
    ipv4_t     ipv4_addr;
  } dev_t;
endpackage

module eth_vlg_mac_tx
  import eth_vlg_pkg::*;
#(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_BYTES   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  dev_t       dev,
  input  logic       req,
  input  mac_addr_t  dst_mac,
  input  ethertype_t ethertype,
  input  logic [7:0] in_dat,
  input  logic       in_val,
  input  logic       in_eof,
  output logic       in_rdy,
  output logic [7:0] phy_dat,
  output logic       phy_val,
  output logic       phy_err,
  output logic       busy,
  output logic       done,
  output logic       len_err
);

  localparam logic [31:0] c_crc_init = 32'hFFFF_FFFF;
  localparam logic [31:0] c_poly     = 32'hEDB8_8320;
  localparam logic [10:0] c_min      = 11'(MIN_PAYLOAD);
  localparam logic [10:0] c_max      = 11'(MAX_PAYLOAD);
  localparam logic [10:0] c_ifg_last = 11'(IFG_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PRE     = 4'd1,
    S_SFD     = 4'd2,
    S_DST     = 4'd3,
    S_SRC     = 4'd4,
    S_TYPE    = 4'd5,
    S_PAYLOAD = 4'd6,
    S_PAD     = 4'd7,
    S_FCS     = 4'd8,
    S_ABORT   = 4'd9,
    S_IFG     = 4'd10
  } state_t;

  state_t      r_state, w_nstate;
  logic [10:0] r_cnt, w_ncnt;
  logic [7:0]  r_phy_dat, w_ndat;
  logic        r_phy_val, w_nval;
  logic        r_phy_err, w_nerr;
  logic        r_in_rdy, w_nrdy;
  logic        r_done, w_ndone;
  logic        r_len_err, w_nlen_err;
  logic [31:0] r_crc;
  mac_addr_t   r_dst;
  ethertype_t  r_type;

  logic [31:0] w_crc_inv;
  logic [1:0]  w_fcs_sel;
  logic [10:0] w_pay_base;
  logic [10:0] w_pay_inc;
  logic        w_crc_en;
  logic        w_unused_dev;

  function automatic logic [31:0] crc8(input logic [31:0] crc, input logic [7:0] dat);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ dat[i]) ? ((c >> 1) ^ c_poly) : (c >> 1);
    end
    return c;
  endfunction

  assign w_unused_dev = ^dev.ipv4_addr;
  assign w_crc_inv    = ~r_crc;
  assign w_fcs_sel    = r_cnt[1:0] + 2'd1;
  // Payload count restarts on the first accepted byte, which arrives in TYPE.
  assign w_pay_base   = (r_state == S_TYPE) ? 11'd0 : r_cnt;
  assign w_pay_inc    = (w_pay_base == c_max) ? w_pay_base : w_pay_base + 11'd1;
  assign w_crc_en     = (w_nstate == S_DST) || (w_nstate == S_SRC) || (w_nstate == S_TYPE) ||
                        (w_nstate == S_PAYLOAD) || (w_nstate == S_PAD);

  // Next-state logic computes the byte to be presented in the following cycle.
  always_comb begin
    w_nstate   = r_state;
    w_ncnt     = r_cnt;
    w_ndat     = 8'h00;
    w_nval     = 1'b0;
    w_nerr     = 1'b0;
    w_nrdy     = 1'b0;
    w_ndone    = 1'b0;
    w_nlen_err = 1'b0;
    if (r_in_rdy) begin
      if (in_val) begin
        w_nstate   = S_PAYLOAD;
        w_ncnt     = w_pay_inc;
        w_ndat     = in_dat;
        w_nval     = 1'b1;
        w_nrdy     = !in_eof && (w_pay_inc != c_max);
        w_nlen_err = !in_eof && (w_pay_inc == c_max);
      end else begin
        w_nstate = S_ABORT;
        w_ncnt   = 11'd0;
        w_nval   = 1'b1;
        w_nerr   = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            w_nstate = S_PRE;
            w_ncnt   = 11'd0;
            w_ndat   = 8'h55;
            w_nval   = 1'b1;
          end
        end
        S_PRE: begin
          w_nval = 1'b1;
          if (r_cnt == 11'd6) begin
            w_nstate = S_SFD;
            w_ndat   = 8'hD5;
          end else begin
            w_ncnt = r_cnt + 11'd1;
            w_ndat = 8'h55;
          end
        end
        S_SFD: begin
          w_nstate = S_DST;
          w_ncnt   = 11'd0;
          w_ndat   = r_dst[5];
          w_nval   = 1'b1;
        end
        S_DST: begin
          w_nval = 1'b1;
          if (r_cnt == 11'd5) begin
            w_nstate = S_SRC;
            w_ncnt   = 11'd0;
            w_ndat   = dev.mac_addr[5];
          end else begin
            w_ncnt = r_cnt + 11'd1;
            w_ndat = r_dst[3'd4 - r_cnt[2:0]];
          end
        end
        S_SRC: begin
          w_nval = 1'b1;
          if (r_cnt == 11'd5) begin
            w_nstate = S_TYPE;
            w_ncnt   = 11'd0;
            w_ndat   = r_type[1];
          end else begin
            w_ncnt = r_cnt + 11'd1;
            w_ndat = dev.mac_addr[3'd4 - r_cnt[2:0]];
          end
        end
        S_TYPE: begin
          w_ncnt = 11'd1;
          w_ndat = r_type[0];
          w_nval = 1'b1;
          w_nrdy = 1'b1;
        end
        S_PAYLOAD, S_PAD: begin
          w_nval = 1'b1;
          if (r_cnt < c_min) begin
            w_nstate = S_PAD;
            w_ncnt   = r_cnt + 11'd1;
          end else begin
            w_nstate = S_FCS;
            w_ncnt   = 11'd0;
            w_ndat   = w_crc_inv[7:0];
          end
        end
        S_FCS: begin
          if (r_cnt == 11'd3) begin
            w_nstate = S_IFG;
            w_ncnt   = 11'd0;
            w_ndone  = 1'b1;
          end else begin
            w_ncnt = r_cnt + 11'd1;
            w_ndat = w_crc_inv[{w_fcs_sel, 3'b000} +: 8];
            w_nval = 1'b1;
          end
        end
        S_ABORT: begin
          w_nstate = S_IFG;
          w_ncnt   = 11'd0;
        end
        S_IFG: begin
          if (r_cnt >= c_ifg_last) begin
            w_nstate = S_IDLE;
            w_ncnt   = 11'd0;
          end else begin
            w_ncnt = r_cnt + 11'd1;
          end
        end
        default: begin
          w_nstate = S_IDLE;
          w_ncnt   = 11'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 11'd0;
      r_phy_dat <= 8'h00;
      r_phy_val <= 1'b0;
      r_phy_err <= 1'b0;
      r_in_rdy  <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      r_crc     <= c_crc_init;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_phy_dat <= w_ndat;
      r_phy_val <= w_nval;
      r_phy_err <= w_nerr;
      r_in_rdy  <= w_nrdy;
      r_done    <= w_ndone;
      r_len_err <= w_nlen_err;
      // CRC tracks the byte being loaded, so it is complete when FCS starts.
      if (r_state == S_IDLE) begin
        r_crc <= c_crc_init;
      end else if (w_crc_en) begin
        r_crc <= crc8(r_crc, w_ndat);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req) begin
      r_dst  <= dst_mac;
      r_type <= ethertype;
    end
  end

  assign in_rdy  = r_in_rdy;
  assign phy_dat = r_phy_dat;
  assign phy_val = r_phy_val;
  assign phy_err = r_phy_err;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign len_err = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_eth_vlg_mac_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_eth_vlg_mac_tx
// Description : Directed self-checking bench for eth_vlg_mac_tx.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_eth_vlg_mac_tx;
  import eth_vlg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  dev_t       dev;
  logic       req;
  mac_addr_t  dst_mac;
  ethertype_t ethertype;
  logic [7:0] in_dat;
  logic       in_val;
  logic       in_eof;
  logic       in_rdy;
  logic [7:0] phy_dat;
  logic       phy_val;
  logic       phy_err;
  logic       busy;
  logic       done;
  logic       len_err;

  eth_vlg_mac_tx #(.MIN_PAYLOAD(46), .MAX_PAYLOAD(1500), .IFG_BYTES(12)) dut (
    .clk(clk), .rst_n(rst_n), .dev(dev), .req(req), .dst_mac(dst_mac),
    .ethertype(ethertype), .in_dat(in_dat), .in_val(in_val), .in_eof(in_eof),
    .in_rdy(in_rdy), .phy_dat(phy_dat), .phy_val(phy_val), .phy_err(phy_err),
    .busy(busy), .done(done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] src_mac = 48'h0200_00AA_BBCC;
  logic [47:0] bcast   = 48'hFFFF_FFFF_FFFF;
  logic [47:0] uni     = 48'h1122_3344_5566;

  // Per-frame capture results
  logic [7:0] cap_q[$];
  int first_val, last_val, done_cnt, done_cyc, len_cnt, len_cyc, err_cnt, err_cyc;
  int rdy_first, rdy_last, lat_err, idle_dat_err, ifg_cnt, end_cyc, accepted;
  logic busy0, busy1;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) x = (x[0] ^ b[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  task automatic calc_fcs(output logic [31:0] got, output logic [31:0] exp_fcs,
                          output logic [31:0] residue);
    logic [31:0] c;
    int n;
    n = cap_q.size();
    got = 32'h0; exp_fcs = 32'h1; residue = 32'h0;
    if (n >= 12) begin
      c = 32'hFFFF_FFFF;
      for (int j = 8; j < n - 4; j++) c = crc_upd(c, cap_q[j]);
      exp_fcs = ~c;
      got = {cap_q[n-1], cap_q[n-2], cap_q[n-3], cap_q[n-4]};
      for (int j = n - 4; j < n; j++) c = crc_upd(c, cap_q[j]);
      residue = c;
    end
  endtask

  // Issues one request and streams payload whenever in_rdy is seen; cycle 0 is the accept cycle.
  task automatic run_frame(input int n_pay, input bit with_eof, input int underrun_at,
                           input logic [47:0] dst, input logic [15:0] etype);
    int idx;
    logic [7:0] pend;
    bit pend_v;
    cap_q.delete();
    first_val = -1; last_val = -1; done_cnt = 0; done_cyc = -1; len_cnt = 0; len_cyc = -1;
    err_cnt = 0; err_cyc = -1; rdy_first = -1; rdy_last = -1; lat_err = 0;
    idle_dat_err = 0; ifg_cnt = 0; end_cyc = -1; idx = 0; pend = 8'h00; pend_v = 1'b0;
    @(negedge clk);
    busy0 = busy;
    dst_mac = dst; ethertype = etype; req = 1'b1;
    in_val = 1'b0; in_eof = 1'b0; in_dat = 8'h00;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (c == 1) busy1 = busy;
      if (pend_v && (!phy_val || phy_dat !== pend)) lat_err++;
      pend_v = 1'b0;
      if (phy_val) begin
        cap_q.push_back(phy_dat);
        if (first_val < 0) first_val = c;
        last_val = c;
      end else begin
        if (phy_dat !== 8'h00) idle_dat_err++;
        if (busy && last_val > 0) ifg_cnt++;
      end
      if (phy_err) begin err_cnt++; err_cyc = c; end
      if (done) begin done_cnt++; done_cyc = c; end
      if (len_err) begin len_cnt++; len_cyc = c; end
      if (in_rdy) begin
        if (rdy_first < 0) rdy_first = c;
        rdy_last = c;
      end
      if (!busy) begin
        end_cyc = c;
        break;
      end
      in_val = 1'b0; in_eof = 1'b0; in_dat = 8'h00;
      if (in_rdy && idx < n_pay && idx != underrun_at) begin
        in_dat = (n_pay == 1) ? 8'hAB : 8'(idx);
        in_val = 1'b1;
        in_eof = with_eof && (idx == n_pay - 1);
        pend   = in_dat;
        pend_v = 1'b1;
        idx++;
      end
    end
    accepted = idx;
    in_val = 1'b0; in_eof = 1'b0; in_dat = 8'h00;
  endtask

  task automatic test_reset;
    n_vec++; if (phy_val !== 1'b0) begin n_err++; $display("FAIL reset_phy_val: got %b want 0", phy_val); end
    n_vec++; if (phy_dat !== 8'h00) begin n_err++; $display("FAIL reset_phy_dat: got %h want 00", phy_dat); end
    n_vec++; if ({phy_err, in_rdy, busy, done, len_err} !== 5'b0)
      begin n_err++; $display("FAIL reset_ctrl: got err/rdy/busy/done/len=%b want 00000", {phy_err, in_rdy, busy, done, len_err}); end
  endtask

  task automatic test_min_frame;
    logic [31:0] got, exp_fcs, res;
    int pre_bad, hdr_bad, pay_bad;
    logic [15:0] ety;
    ety = 16'h0806;
    run_frame(46, 1'b1, -1, bcast, ety);
    pre_bad = 0; hdr_bad = 0; pay_bad = 0;
    for (int j = 0; j < 7; j++) if (cap_q[j] !== 8'h55) pre_bad++;
    if (cap_q[7] !== 8'hD5) pre_bad++;
    for (int j = 0; j < 6; j++) begin
      if (cap_q[8+j]  !== bcast[47-8*j -: 8])   hdr_bad++;
      if (cap_q[14+j] !== src_mac[47-8*j -: 8]) hdr_bad++;
    end
    if (cap_q[20] !== 8'h08 || cap_q[21] !== 8'h06) hdr_bad++;
    for (int j = 0; j < 46; j++) if (cap_q[22+j] !== 8'(j)) pay_bad++;
    calc_fcs(got, exp_fcs, res);
    n_vec++; if (end_cyc !== 85) begin n_err++; $display("FAIL min_end_cycle: got %0d want 85", end_cyc); end
    n_vec++; if (cap_q.size() !== 72) begin n_err++; $display("FAIL min_val_cycles: got %0d want 72", cap_q.size()); end
    n_vec++; if (first_val !== 1 || last_val !== 72) begin n_err++; $display("FAIL min_val_window: got %0d..%0d want 1..72", first_val, last_val); end
    n_vec++; if (pre_bad !== 0) begin n_err++; $display("FAIL min_preamble: got %0d bad bytes want 0", pre_bad); end
    n_vec++; if (hdr_bad !== 0) begin n_err++; $display("FAIL min_header: got %0d bad bytes want 0", hdr_bad); end
    n_vec++; if (pay_bad !== 0) begin n_err++; $display("FAIL min_payload: got %0d bad bytes want 0", pay_bad); end
    n_vec++; if (got !== exp_fcs) begin n_err++; $display("FAIL min_fcs: got %h want %h", got, exp_fcs); end
    n_vec++; if (res !== 32'hDEBB20E3) begin n_err++; $display("FAIL min_residue: got %h want debb20e3", res); end
    n_vec++; if (done_cnt !== 1 || done_cyc !== 73) begin n_err++; $display("FAIL min_done: got %0d pulses at %0d want 1 at 73", done_cnt, done_cyc); end
    n_vec++; if (rdy_first !== 22 || rdy_last !== 67) begin n_err++; $display("FAIL min_in_rdy: got %0d..%0d want 22..67", rdy_first, rdy_last); end
    n_vec++; if (lat_err !== 0) begin n_err++; $display("FAIL min_latency: got %0d late bytes want 0", lat_err); end
    n_vec++; if (ifg_cnt !== 12) begin n_err++; $display("FAIL min_ifg: got %0d want 12", ifg_cnt); end
    n_vec++; if (idle_dat_err !== 0) begin n_err++; $display("FAIL min_idle_dat: got %0d nonzero want 0", idle_dat_err); end
    n_vec++; if (busy0 !== 1'b0 || busy1 !== 1'b1) begin n_err++; $display("FAIL min_busy: got c0=%b c1=%b want 0 1", busy0, busy1); end
    n_vec++; if (err_cnt !== 0 || len_cnt !== 0) begin n_err++; $display("FAIL min_no_err: got err=%0d len=%0d want 0 0", err_cnt, len_cnt); end
  endtask

  task automatic test_pad;
    logic [31:0] got, exp_fcs, res;
    int pad_bad;
    run_frame(1, 1'b1, -1, uni, 16'h0800);
    pad_bad = 0;
    for (int j = 23; j < 68; j++) if (cap_q[j] !== 8'h00) pad_bad++;
    calc_fcs(got, exp_fcs, res);
    n_vec++; if (cap_q.size() - 8 !== 64) begin n_err++; $display("FAIL pad_len: got %0d want 64", cap_q.size() - 8); end
    n_vec++; if (cap_q[22] !== 8'hAB) begin n_err++; $display("FAIL pad_data: got %h want ab", cap_q[22]); end
    n_vec++; if (pad_bad !== 0) begin n_err++; $display("FAIL pad_zero: got %0d nonzero want 0", pad_bad); end
    n_vec++; if (res !== 32'hDEBB20E3 || got !== exp_fcs) begin n_err++; $display("FAIL pad_fcs: got %h res %h want %h res debb20e3", got, res, exp_fcs); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL pad_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_max_len;
    logic [31:0] got, exp_fcs, res;
    run_frame(1600, 1'b0, -1, uni, 16'h88B5);
    calc_fcs(got, exp_fcs, res);
    n_vec++; if (accepted !== 1500) begin n_err++; $display("FAIL max_accepted: got %0d want 1500", accepted); end
    n_vec++; if (rdy_last !== 1521) begin n_err++; $display("FAIL max_rdy_drop: got last %0d want 1521", rdy_last); end
    n_vec++; if (len_cnt !== 1 || len_cyc !== 1522) begin n_err++; $display("FAIL max_len_err: got %0d at %0d want 1 at 1522", len_cnt, len_cyc); end
    n_vec++; if (cap_q.size() - 8 !== 1518) begin n_err++; $display("FAIL max_frame_len: got %0d want 1518", cap_q.size() - 8); end
    n_vec++; if (cap_q[22+1499] !== 8'hDB) begin n_err++; $display("FAIL max_last_byte: got %h want db", cap_q[22+1499]); end
    n_vec++; if (res !== 32'hDEBB20E3 || got !== exp_fcs) begin n_err++; $display("FAIL max_fcs: got %h res %h want %h res debb20e3", got, res, exp_fcs); end
    n_vec++; if (end_cyc !== 1539) begin n_err++; $display("FAIL max_end_cycle: got %0d want 1539", end_cyc); end
  endtask

  task automatic test_underrun;
    run_frame(46, 1'b1, 9, uni, 16'h0800);
    n_vec++; if (err_cnt !== 1 || err_cyc !== 32) begin n_err++; $display("FAIL ur_err: got %0d at %0d want 1 at 32", err_cnt, err_cyc); end
    n_vec++; if (cap_q.size() !== 32 || cap_q[31] !== 8'h00) begin n_err++; $display("FAIL ur_no_fcs: got %0d bytes last %h want 32 last 00", cap_q.size(), cap_q[31]); end
    n_vec++; if (ifg_cnt !== 12 || end_cyc !== 45) begin n_err++; $display("FAIL ur_ifg: got %0d idle end %0d want 12 end 45", ifg_cnt, end_cyc); end
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL ur_done: got %0d want 0", done_cnt); end
    n_vec++; if (idle_dat_err !== 0) begin n_err++; $display("FAIL ur_idle_dat: got %0d want 0", idle_dat_err); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d8;
    @(negedge clk);
    dst_mac = uni; ethertype = 16'h0800; req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      req = 1'b0;
    end
    n_vec++; if (phy_val !== 1'b1 || phy_dat !== src_mac[31:24]) begin n_err++; $display("FAIL rst_mid_src: got val %b dat %h want 1 %h", phy_val, phy_dat, src_mac[31:24]); end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({phy_dat, phy_val, phy_err, in_rdy, busy, done, len_err} !== 14'h0)
      begin n_err++; $display("FAIL rst_mid_clear: got %h want 0000", {phy_dat, phy_val, phy_err, in_rdy, busy, done, len_err}); end
    rst_n = 1'b1;
    @(negedge clk);
    req = 1'b1; in_eof = 1'b1; in_val = 1'b1;
    @(negedge clk);
    req = 1'b0; in_eof = 1'b0; in_val = 1'b0;
    n_vec++; if (phy_val !== 1'b1 || phy_dat !== 8'h55 || in_rdy !== 1'b0) begin n_err++; $display("FAIL rst_restart_c1: got val %b dat %h rdy %b want 1 55 0", phy_val, phy_dat, in_rdy); end
    repeat (7) @(negedge clk);
    d8 = phy_dat;
    n_vec++; if (d8 !== 8'hD5) begin n_err++; $display("FAIL rst_restart_sfd: got %h want d5", d8); end
    // Let the frame run out (no payload offered -> underrun) so the DUT is idle again.
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_restart_idle: got busy %b want 0", busy); end
  endtask

  // req stays high throughout; the next frame starts one accept cycle after the 12-cycle IFG.
  task automatic test_back_to_back;
    int idx, dcnt, last_done, val_run, gap_busy, bad_run, bad_gap, gaps, bad_period;
    bit seen_val;
    idx = 0; dcnt = 0; last_done = -1; val_run = 0; gap_busy = 0;
    bad_run = 0; bad_gap = 0; gaps = 0; bad_period = 0; seen_val = 1'b0;
    @(negedge clk);
    dst_mac = bcast; ethertype = 16'h0806; req = 1'b1;
    for (int c = 1; c < 1000 && dcnt < 3; c++) begin
      @(negedge clk);
      if (phy_val) begin
        if (val_run == 0 && seen_val) begin
          gaps++;
          if (gap_busy != 12) bad_gap++;
        end
        val_run++;
        seen_val = 1'b1;
        gap_busy = 0;
      end else begin
        if (val_run > 0) begin
          if (val_run != 72) bad_run++;
          val_run = 0;
        end
        if (busy) gap_busy++;
      end
      if (done) begin
        if (last_done >= 0 && (c - last_done) != 85) bad_period++;
        last_done = c;
        dcnt++;
        if (dcnt == 3) req = 1'b0;
      end
      in_val = 1'b0; in_eof = 1'b0; in_dat = 8'h00;
      if (in_rdy) begin
        in_val = 1'b1; in_dat = 8'(idx); in_eof = (idx == 45);
        idx = (idx == 45) ? 0 : idx + 1;
      end
    end
    req = 1'b0; in_val = 1'b0; in_eof = 1'b0;
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    n_vec++; if (dcnt !== 3) begin n_err++; $display("FAIL b2b_frames: got %0d want 3", dcnt); end
    n_vec++; if (bad_run !== 0) begin n_err++; $display("FAIL b2b_frame_len: got %0d bad want 0", bad_run); end
    n_vec++; if (gaps !== 2 || bad_gap !== 0) begin n_err++; $display("FAIL b2b_ifg: got %0d gaps %0d bad want 2 0", gaps, bad_gap); end
    n_vec++; if (bad_period !== 0) begin n_err++; $display("FAIL b2b_period: got %0d bad want 0", bad_period); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
  endtask

  initial begin
    dev.mac_addr  = src_mac;
    dev.ipv4_addr = 32'hC0A8_0001;
    req = 1'b0; dst_mac = '0; ethertype = '0;
    in_dat = 8'h00; in_val = 1'b0; in_eof = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_min_frame;
    test_pad;
    test_max_len;
    test_underrun;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
